// File: rtl/spi_slave.sv
// spi_slave: SPI frame receiver/transmitter bridging a serial master to a RAM-style rx/tx word interface.
module spi_slave #(
    parameter int TX_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       SS_n,
    input  logic       MOSI,
    output logic       MISO,
    output logic [9:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid
);
    localparam int WW = $clog2(TX_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, SEND, DONE} state_t;

    state_t        state, state_n;
    logic [8:0]    rx_shift;
    logic [3:0]    bit_cnt;
    logic [7:0]    tx_shift;
    logic [3:0]    tx_cnt;
    logic [WW-1:0] wait_cnt;
    logic          sending;
    logic          addr_flag;
    logic          abort;
    logic          tx_expire;
    logic          shift_end;

    assign abort     = state != IDLE && SS_n;
    assign tx_expire = state == SEND && !sending && !tx_valid && wait_cnt == WW'(TX_TIMEOUT - 1);
    assign shift_end = state == SEND && sending && tx_cnt == 4'd8;

    always_comb begin
        state_n = state;
        if (abort)
            state_n = IDLE;
        else
            case (state)
                IDLE:            state_n = SS_n ? IDLE : CHK_CMD;
                CHK_CMD:         state_n = !MOSI ? WRITE : addr_flag ? READ_DATA : READ_ADD;
                WRITE, READ_ADD: state_n = bit_cnt == 4'd8 ? DONE : state;
                READ_DATA:       state_n = bit_cnt == 4'd8 ? SEND : state;
                SEND:            state_n = (tx_expire || shift_end) ? DONE : SEND;
                default:         state_n = state;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            bit_cnt   <= '0;
            tx_shift  <= '0;
            tx_cnt    <= '0;
            wait_cnt  <= '0;
            sending   <= 1'b0;
            addr_flag <= 1'b0;
            MISO      <= 1'b0;
        end else begin
            state    <= state_n;
            rx_valid <= 1'b0;
            if (abort) begin
                rx_shift <= '0;
                bit_cnt  <= '0;
                tx_cnt   <= '0;
                wait_cnt <= '0;
                sending  <= 1'b0;
                MISO     <= 1'b0;
            end else
                case (state)
                    CHK_CMD: rx_shift <= {8'b0, MOSI};
                    WRITE, READ_ADD, READ_DATA: begin
                        rx_shift <= {rx_shift[7:0], MOSI};
                        bit_cnt  <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd8) begin
                            rx_data  <= {rx_shift, MOSI};
                            rx_valid <= 1'b1;
                            bit_cnt  <= '0;
                            wait_cnt <= '0;
                            addr_flag <= state == READ_ADD ? 1'b1 : state == READ_DATA ? 1'b0 : addr_flag;
                        end
                    end
                    SEND: begin
                        // MISO is registered, so the MSB goes out together with the load
                        if (!sending) begin
                            if (tx_valid) begin
                                tx_shift <= {tx_data[6:0], 1'b0};
                                MISO     <= tx_data[7];
                                sending  <= 1'b1;
                                tx_cnt   <= 4'd1;
                            end else
                                wait_cnt <= wait_cnt + 1'b1;
                        end else if (tx_cnt == 4'd8) begin
                            MISO    <= 1'b0;
                            sending <= 1'b0;
                            tx_cnt  <= '0;
                        end else begin
                            MISO     <= tx_shift[7];
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            tx_cnt   <= tx_cnt + 4'd1;
                        end
                    end
                    default: begin
                        bit_cnt  <= '0;
                        tx_cnt   <= '0;
                        wait_cnt <= '0;
                        sending  <= 1'b0;
                        MISO     <= 1'b0;
                    end
                endcase
        end
    end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: randomized frame stimulus with a queue scoreboard and a per-cycle MISO expectation map.
module tb_spi_slave;
    localparam int TX_TIMEOUT = 4;

    logic       clk = 0, rst_n = 0, SS_n = 1, MOSI = 0, tx_valid = 0;
    logic [7:0] tx_data = 0;
    logic       MISO, rx_valid;
    logic [9:0] rx_data;

    int total = 0, bad = 0, cyc = 0;
    bit model_addr = 0;

    typedef struct {
        logic [9:0] w;
        int         c;
    } rx_t;
    rx_t rx_q[$];
    bit  exp_miso[int];

    spi_slave #(.TX_TIMEOUT(TX_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        rx_t e;
        if (rst_n) begin
            check("miso", 32'(MISO), exp_miso.exists(cyc) ? 32'(exp_miso[cyc]) : 32'd0);
            if (rx_valid) begin
                if (rx_q.size() == 0)
                    check("rx_valid_unexpected", 32'd1, 32'd0);
                else begin
                    e = rx_q.pop_front();
                    check("rx_data", 32'(rx_data), 32'(e.w));
                    check("rx_cycle", cyc, e.c);
                end
            end
        end
    end

    // one SS_n-low frame; k>0 pulses tx_valid k cycles after the last data bit is sampled
    task automatic frame(input logic [9:0] w, input int k, input logic [7:0] td,
                         input int abort_at, input int rst_at);
        int c0;
        SS_n = 0;
        MOSI = 1'($urandom);
        tx_valid = 0;
        @(posedge clk); #1;
        c0 = cyc;
        if (abort_at == 0) begin
            rx_q.push_back('{w, c0 + 10});
            if (w[9]) begin
                if (model_addr && k >= 1 && k <= TX_TIMEOUT)
                    for (int i = 0; i < 8; i++) exp_miso[c0 + 10 + k + i] = td[7 - i];
                model_addr = !model_addr;
            end
        end
        for (int j = 1; j <= 24; j++) begin
            if (j == abort_at) break;
            if (j == rst_at) begin
                for (int i = cyc; i < cyc + 24; i++) if (exp_miso.exists(i)) exp_miso.delete(i);
                model_addr = 0;
                SS_n = 1;
                tx_valid = 0;
                rst_n = 0;
                #1;
                check("miso_async_reset", 32'(MISO), 32'd0);
                #1;
                rst_n = 1;
                break;
            end
            MOSI = j <= 10 ? w[10 - j] : 1'($urandom);
            tx_valid = k > 0 && (j == 10 + k || j == 13 + k);
            tx_data = j == 10 + k ? td : 8'($urandom);
            @(posedge clk); #1;
        end
        SS_n = 1;
        tx_valid = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        rst_n = 1;
        @(posedge clk); #1;
        frame(10'b00_0001_0100, 0, 8'h00, 0, 0);
        frame(10'b10_0001_0100, 2, 8'h77, 0, 0);
        frame(10'b11_0101_1010, 2, 8'hA5, 0, 0);
        frame(10'b10_0000_0001, 0, 8'h00, 0, 0);
        frame(10'b11_0000_0001, 0, 8'h00, 0, 0);
        frame(10'b10_0000_0010, 0, 8'h00, 0, 0);
        frame(10'b11_0000_0010, TX_TIMEOUT, 8'hC3, 0, 0);
        frame(10'b10_0000_0011, 0, 8'h00, 0, 0);
        frame(10'b11_0000_0011, TX_TIMEOUT + 1, 8'hE7, 0, 0);
        frame(10'b01_1100_1010, 0, 8'h00, 6, 0);
        frame(10'b01_1100_1010, 0, 8'h00, 10, 0);
        frame(10'b01_1100_1011, 3, 8'h99, 0, 0);
        frame(10'b10_0100_0000, 0, 8'h00, 0, 0);
        frame(10'b11_0100_0000, 1, 8'hFF, 0, 14);
        frame(10'b10_0011_1100, 1, 8'h3C, 0, 0);
        frame(10'b11_0011_1100, 3, 8'h5A, 0, 0);
        for (int n = 0; n < 40; n++)
            frame(10'($urandom), int'($urandom_range(0, 6)), 8'($urandom),
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 10)) : 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("rx_queue_empty", rx_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
